// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART: TX/RX state encodings, parity
// mode constants, and helpers that derive the bit divisor and bit-timer width
// from the clock and line rates.
// Optional feature macro used by uart_core: UART_LOOPBACK_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Transmit sequencer states, in frame order
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } txState_t;

   // Receive sequencer states; RX_BREAK holds off until the line returns high
   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4,
      RX_BREAK  = 3'd5
   } rxState_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // Clock cycles per serial bit
   function automatic int calcDivisor(input int clockRate, input int baudRate);
      return clockRate / baudRate;
   endfunction

   // Timer must reach the longest interval counted: the whole stop period
   function automatic int timerWidth(input int divisor, input int stopBits);
      return $clog2(divisor * stopBits + 1);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// First-word-fall-through FIFO used for both UART directions. Push while full
// is ignored unless a pop happens in the same cycle; pop while empty is ignored.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push          write i_pushData
//   i_pushData      write data, WIDTH bits
//   i_pop           drop the head entry
//   o_popData       head entry (valid while o_empty=0, zero after reset)
//   o_full/o_empty  occupancy flags
// -----------------------------------------------------------------------------
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_popData,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_popData = r_mem[r_rdPtr];

   // A pop frees a slot in the same cycle, so a full FIFO still takes a push
   assign w_doPop  = i_pop && !o_empty;
   assign w_doPush = i_push && (!o_full || w_doPop);

   // Storage and pointers; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= r_wrPtr + AW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         if (w_doPush && !w_doPop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_doPush && w_doPop) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
// Full-duplex UART with TX and RX FIFOs, configurable data bits, parity and
// stop bits. RX input is synchronised, sampled mid-bit, and bad frames are
// dropped with sticky error flags.
// Optional feature: define UART_LOOPBACK_EN to let 'loopback' route the
// internal transmit line into the receiver (pin Tx held high meanwhile).
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   send_flag/data    push into TX FIFO (ignored while full)
//   recv_flag/data    pop / head of RX FIFO (first-word fall-through)
//   sendable          TX FIFO not full
//   receivable        RX FIFO not empty
//   tx_busy           transmitter mid-frame
//   err_parity/frame/overrun  sticky error flags, err_clear clears them
//   loopback          internal loopback select
//   Tx, Rx            serial pins, idle high
// -----------------------------------------------------------------------------
module uart_core
   import uart_pkg::*;
#(
   parameter int CLOCKRATE  = 100000000,
   parameter int BAUDRATE   = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 1,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 send_flag,
   input  logic [DATA_BITS-1:0] send_data,
   input  logic                 recv_flag,
   output logic [DATA_BITS-1:0] recv_data,
   output logic                 sendable,
   output logic                 receivable,
   output logic                 tx_busy,
   output logic                 err_parity,
   output logic                 err_frame,
   output logic                 err_overrun,
   input  logic                 err_clear,
   input  logic                 loopback,
   output logic                 Tx,
   input  logic                 Rx
);
   localparam int               DIVISOR   = calcDivisor(CLOCKRATE, BAUDRATE);
   localparam int               TW        = timerWidth(DIVISOR, STOP_BITS);
   localparam logic [TW-1:0]    BIT_END   = TW'(DIVISOR - 1);
   localparam logic [TW-1:0]    STOP_END  = TW'(STOP_BITS * DIVISOR - 1);
   localparam logic [TW-1:0]    SAMPLE_PT = TW'(DIVISOR / 2);
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic             PAR_INV   = (PARITY == PARITY_ODD);

   // ---------------- FIFOs ----------------
   logic [DATA_BITS-1:0] w_txHead;
   logic                 w_txFull, w_txEmpty, w_txPop;
   logic                 w_rxFull, w_rxEmpty, w_rxPush;
   logic [DATA_BITS-1:0] r_rxShift;

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txFifo (
      .i_clk(CLK), .i_rst_n(RST_N),
      .i_push(send_flag), .i_pushData(send_data), .i_pop(w_txPop),
      .o_popData(w_txHead), .o_full(w_txFull), .o_empty(w_txEmpty)
   );

   uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxFifo (
      .i_clk(CLK), .i_rst_n(RST_N),
      .i_push(w_rxPush), .i_pushData(r_rxShift), .i_pop(recv_flag),
      .o_popData(recv_data), .o_full(w_rxFull), .o_empty(w_rxEmpty)
   );

   assign sendable   = !w_txFull;
   assign receivable = !w_rxEmpty;

   // ---------------- Transmitter ----------------
   txState_t             r_txState, w_txNext;
   logic [TW-1:0]        r_txTimer;
   logic [2:0]           r_txBitCnt;
   logic [DATA_BITS-1:0] r_txShift;
   logic                 r_txParity;
   logic                 w_txBitEnd, w_txStopEnd, w_txLine;

   assign w_txBitEnd  = (r_txTimer == BIT_END);
   assign w_txStopEnd = (r_txTimer == STOP_END);
   assign tx_busy     = (r_txState != TX_IDLE);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_txState <= TX_IDLE;
      else        r_txState <= w_txNext;
   end

   // End of stop goes straight to START when more data waits: no idle gap
   always_comb begin
      w_txNext = r_txState;
      case (r_txState)
         TX_IDLE:   if (!w_txEmpty) w_txNext = TX_START;
         TX_START:  if (w_txBitEnd) w_txNext = TX_DATA;
         TX_DATA:   if (w_txBitEnd && r_txBitCnt == LAST_BIT)
                       w_txNext = (PARITY == PARITY_NONE) ? TX_STOP : TX_PARITY;
         TX_PARITY: if (w_txBitEnd) w_txNext = TX_STOP;
         TX_STOP:   if (w_txStopEnd) w_txNext = w_txEmpty ? TX_IDLE : TX_START;
         default:   w_txNext = TX_IDLE;
      endcase
   end

   always_comb begin
      w_txPop  = 1'b0;
      w_txLine = 1'b1;
      case (r_txState)
         TX_IDLE:   w_txPop  = !w_txEmpty;
         TX_START:  w_txLine = 1'b0;
         TX_DATA:   w_txLine = r_txShift[0];
         TX_PARITY: w_txLine = r_txParity;
         TX_STOP:   w_txPop  = w_txStopEnd && !w_txEmpty;
         default:   w_txLine = 1'b1;
      endcase
   end

   // Bit timer, data shifter and parity capture for the frame being sent
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_txTimer  <= '0;
         r_txBitCnt <= '0;
         r_txShift  <= '0;
         r_txParity <= 1'b0;
      end else if (w_txPop) begin
         r_txShift  <= w_txHead;
         r_txParity <= (^w_txHead) ^ PAR_INV;
         r_txTimer  <= '0;
         r_txBitCnt <= '0;
      end else if (r_txState != TX_IDLE) begin
         if ((r_txState == TX_STOP) ? w_txStopEnd : w_txBitEnd) r_txTimer <= '0;
         else                                                  r_txTimer <= r_txTimer + TW'(1);
         if (r_txState == TX_DATA && w_txBitEnd) begin
            r_txShift  <= r_txShift >> 1;
            r_txBitCnt <= r_txBitCnt + 3'd1;
         end
      end
   end

   // ---------------- Loopback selection ----------------
   logic w_rxIn;
`ifdef UART_LOOPBACK_EN
   assign w_rxIn = loopback ? w_txLine : Rx;
   assign Tx     = loopback ? 1'b1 : w_txLine;
`else
   logic w_unusedLoopback;
   assign w_unusedLoopback = loopback;
   assign w_rxIn = Rx;
   assign Tx     = w_txLine;
`endif

   // ---------------- Receiver ----------------
   rxState_t      r_rxState, w_rxNext;
   logic [1:0]    r_rxSync;
   logic          r_rxPrev;
   logic [TW-1:0] r_rxTimer;
   logic [2:0]    r_rxBitCnt;
   logic          r_rxParBit;
   logic          w_rxBit, w_rxFall, w_rxSample, w_rxBitEnd, w_rxParOk;
   logic          w_setParity, w_setFrame, w_setOverrun;

   assign w_rxBit    = r_rxSync[1];
   assign w_rxFall   = r_rxPrev & ~w_rxBit;
   assign w_rxSample = (r_rxTimer == SAMPLE_PT);
   assign w_rxBitEnd = (r_rxTimer == BIT_END);
   assign w_rxParOk  = (PARITY == PARITY_NONE) || (r_rxParBit == ((^r_rxShift) ^ PAR_INV));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_rxState <= RX_IDLE;
      else        r_rxState <= w_rxNext;
   end

   // A start bit that is high again at mid-bit was a glitch; a low stop bit
   // parks in RX_BREAK so a held-low line cannot look like a new start
   always_comb begin
      w_rxNext = r_rxState;
      case (r_rxState)
         RX_IDLE:   if (w_rxFall) w_rxNext = RX_START;
         RX_START:  if (w_rxSample && w_rxBit) w_rxNext = RX_IDLE;
                    else if (w_rxBitEnd)       w_rxNext = RX_DATA;
         RX_DATA:   if (w_rxBitEnd && r_rxBitCnt == LAST_BIT)
                       w_rxNext = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
         RX_PARITY: if (w_rxBitEnd) w_rxNext = RX_STOP;
         RX_STOP:   if (w_rxSample) w_rxNext = w_rxBit ? RX_IDLE : RX_BREAK;
         RX_BREAK:  if (w_rxBit) w_rxNext = RX_IDLE;
         default:   w_rxNext = RX_IDLE;
      endcase
   end

   // Exactly one frame outcome at the stop sample, in priority order
   always_comb begin
      w_rxPush     = 1'b0;
      w_setFrame   = 1'b0;
      w_setParity  = 1'b0;
      w_setOverrun = 1'b0;
      if (r_rxState == RX_STOP && w_rxSample) begin
         if (!w_rxBit)        w_setFrame   = 1'b1;
         else if (!w_rxParOk) w_setParity  = 1'b1;
         else if (w_rxFull)   w_setOverrun = 1'b1;
         else                 w_rxPush     = 1'b1;
      end
   end

   // Synchroniser (reset to idle-high), bit timer and data/parity capture
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rxSync   <= 2'b11;
         r_rxPrev   <= 1'b1;
         r_rxTimer  <= '0;
         r_rxBitCnt <= '0;
         r_rxShift  <= '0;
         r_rxParBit <= 1'b0;
      end else begin
         r_rxSync <= {r_rxSync[0], w_rxIn};
         r_rxPrev <= w_rxBit;
         if (r_rxState == RX_IDLE || r_rxState == RX_BREAK) begin
            r_rxTimer  <= '0;
            r_rxBitCnt <= '0;
         end else begin
            r_rxTimer <= w_rxBitEnd ? '0 : r_rxTimer + TW'(1);
            if (r_rxState == RX_DATA && w_rxSample) r_rxShift <= {w_rxBit, r_rxShift[DATA_BITS-1:1]};
            if (r_rxState == RX_DATA && w_rxBitEnd) r_rxBitCnt <= r_rxBitCnt + 3'd1;
            if (r_rxState == RX_PARITY && w_rxSample) r_rxParBit <= w_rxBit;
         end
      end
   end

   // Sticky error flags; a new error beats err_clear in the same cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err_parity  <= 1'b0;
         err_frame   <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_parity  <= w_setParity  | (err_parity  & ~err_clear);
         err_frame   <= w_setFrame   | (err_frame   & ~err_clear);
         err_overrun <= w_setOverrun | (err_overrun & ~err_clear);
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// -----------------------------------------------------------------------------
// tb_uart_core
// Bench for uart_core at DIVISOR=16, 8E1, FIFO_DEPTH=4. The serial input is
// either driven by the bench or tied back to Tx outside the DUT.
// -----------------------------------------------------------------------------
module tb_uart_core;
   localparam int DIV   = 16;
   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       send_flag = 1'b0;
   logic [7:0] send_data = 8'h00;
   logic       recv_flag = 1'b0;
   logic       err_clear = 1'b0;
   logic       loopback = 1'b0;
   logic       useLoop = 1'b0;
   logic       rxDrive = 1'b1;
   wire  [7:0] recv_data;
   wire        sendable, receivable, tx_busy, err_parity, err_frame, err_overrun, Tx;
   wire        Rx;

   assign Rx = useLoop ? Tx : rxDrive;

   uart_core #(
      .CLOCKRATE(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(1),
      .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .send_flag(send_flag), .send_data(send_data),
      .recv_flag(recv_flag), .recv_data(recv_data),
      .sendable(sendable), .receivable(receivable), .tx_busy(tx_busy),
      .err_parity(err_parity), .err_frame(err_frame), .err_overrun(err_overrun),
      .err_clear(err_clear), .loopback(loopback),
      .Tx(Tx), .Rx(Rx)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // Reference model: received byte queue and sticky flags
   logic [7:0] rxQ[$];
   bit         mPar = 0, mFrame = 0, mOver = 0;

   typedef struct {
      logic [7:0] data;
      bit         parFlip;
      bit         stopVal;
      int         extraLow;
      bit         expStore;
      bit         expPar;
      bit         expFrame;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] d);
      send_flag = 1'b1;
      send_data = d;
      step(1);
      send_flag = 1'b0;
   endtask

   task automatic popOne();
      recv_flag = 1'b1;
      step(1);
      recv_flag = 1'b0;
      if (rxQ.size() > 0) rxQ.delete(0);
   endtask

   task automatic clearErrors();
      err_clear = 1'b1;
      step(1);
      err_clear = 1'b0;
      mPar = 0; mFrame = 0; mOver = 0;
   endtask

   // Drive one serial frame onto Rx: start, 8 data LSB first, even parity
   // (optionally inverted), stop bit, optional extra low time, one idle bit
   task automatic applyStimulus(input logic [7:0] d, input bit parFlip, input bit stopVal, input int extraLow);
      rxDrive = 1'b0;
      step(DIV);
      for (int i = 0; i < 8; i++) begin
         rxDrive = d[i];
         step(DIV);
      end
      rxDrive = (^d) ^ parFlip;
      step(DIV);
      rxDrive = stopVal;
      step(DIV);
      if (!stopVal) step(extraLow);
      rxDrive = 1'b1;
      step(DIV);
   endtask

   // Outcome of a received frame according to the error priority rules
   task automatic modelFrame(input logic [7:0] d, input bit parFlip, input bit stopVal);
      if (!stopVal)                 mFrame = 1;
      else if (parFlip)             mPar = 1;
      else if (rxQ.size() == DEPTH) mOver = 1;
      else                          rxQ.push_back(d);
   endtask

   task automatic checkRxState(input string name);
      checkOutput({name, "_rcv"}, receivable, (rxQ.size() != 0));
      if (rxQ.size() != 0) checkOutput({name, "_data"}, recv_data, rxQ[0]);
      checkOutput({name, "_errPar"}, err_parity, mPar);
      checkOutput({name, "_errFrm"}, err_frame, mFrame);
      checkOutput({name, "_errOvr"}, err_overrun, mOver);
   endtask

   task automatic drain(input string name);
      while (rxQ.size() > 0) begin
         checkRxState(name);
         popOne();
      end
      checkOutput({name, "_empty"}, receivable, 0);
   endtask

   task automatic waitTxIdle(input int limit);
      int n = 0;
      while (tx_busy === 1'b1 && n < limit) begin
         step(1);
         n++;
      end
      checkOutput("txIdleTimeout", tx_busy, 0);
   endtask

   initial begin
      vec_t       vecs[6];
      logic [7:0] frameBits;
      logic [10:0] expBits;
      logic       seen;
      int         busyAll;
      logic [7:0] fullBytes[5];
      int         got;

      // ---------- reset values ----------
      step(3);
      checkOutput("rst_Tx", Tx, 1);
      checkOutput("rst_busy", tx_busy, 0);
      checkOutput("rst_sendable", sendable, 1);
      checkOutput("rst_receivable", receivable, 0);
      checkOutput("rst_recvData", recv_data, 0);
      checkOutput("rst_errs", {err_parity, err_frame, err_overrun}, 0);
      RST_N = 1'b1;
      step(2);

      // Pop while empty has no effect
      recv_flag = 1'b1;
      step(1);
      recv_flag = 1'b0;
      checkOutput("popEmpty", receivable, 0);

      // ---------- transmit 0xA5: 11 bits of 16 cycles ----------
      frameBits = 8'hA5;
      expBits   = {1'b1, ^frameBits, frameBits, 1'b0};
      push(8'hA5);
      checkOutput("txIdleBeforeStart", Tx, 1);
      checkOutput("txBusyBeforeStart", tx_busy, 0);
      step(1);
      busyAll = 1;
      for (int b = 0; b < 11; b++) begin
         seen = expBits[b];
         for (int c = 0; c < DIV; c++) begin
            if (Tx !== expBits[b]) seen = Tx;
            if (tx_busy !== 1'b1) busyAll = 0;
            step(1);
         end
         checkOutput($sformatf("txBit%0d", b), seen, expBits[b]);
      end
      checkOutput("txBusyThroughout", busyAll, 1);
      checkOutput("txIdleAfter176", tx_busy, 0);
      checkOutput("txLineIdle", Tx, 1);

      // ---------- table-driven receive frames ----------
      vecs[0] = '{8'h5A, 1'b1, 1'b1, 0,  1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h12, 1'b0, 1'b0, 48, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{8'h3C, 1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 1'b0, 1'b1, 0,  1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h81, 1'b1, 1'b1, 0,  1'b0, 1'b1, 1'b0};
      for (int v = 0; v < 6; v++) begin
         clearErrors();
         applyStimulus(vecs[v].data, vecs[v].parFlip, vecs[v].stopVal, vecs[v].extraLow);
         checkOutput($sformatf("vec%0d_rcv", v), receivable, vecs[v].expStore);
         if (vecs[v].expStore) checkOutput($sformatf("vec%0d_data", v), recv_data, vecs[v].data);
         checkOutput($sformatf("vec%0d_errPar", v), err_parity, vecs[v].expPar);
         checkOutput($sformatf("vec%0d_errFrm", v), err_frame, vecs[v].expFrame);
         checkOutput($sformatf("vec%0d_errOvr", v), err_overrun, 0);
         if (vecs[v].expStore) popOne();
         clearErrors();
         checkOutput($sformatf("vec%0d_cleared", v), {err_parity, err_frame, err_overrun}, 0);
      end
      rxQ.delete();

      // ---------- randomized receive frames vs model ----------
      clearErrors();
      for (int f = 0; f < 16; f++) begin
         logic [7:0] d;
         bit pf, sv;
         d  = 8'($urandom_range(0, 255));
         pf = ($urandom_range(0, 3) == 0);
         sv = ($urandom_range(0, 3) != 0);
         applyStimulus(d, pf, sv, $urandom_range(0, 40));
         modelFrame(d, pf, sv);
         checkRxState($sformatf("rnd%0d", f));
         if ($urandom_range(0, 2) == 0) popOne();
         if ($urandom_range(0, 4) == 0) clearErrors();
      end
      drain("rndDrain");

      // ---------- overrun: five good frames, no pops ----------
      clearErrors();
      for (int f = 0; f < 5; f++) begin
         logic [7:0] d;
         d = 8'($urandom_range(0, 255));
         applyStimulus(d, 1'b0, 1'b1, 0);
         modelFrame(d, 1'b0, 1'b1);
      end
      checkOutput("ovr_flag", err_overrun, mOver);
      drain("ovrDrain");

      // ---------- external loopback: back-to-back transmit ----------
      clearErrors();
      useLoop = 1'b1;
      push(8'h00); push(8'hFF); push(8'h3C);
      rxQ.push_back(8'h00); rxQ.push_back(8'hFF); rxQ.push_back(8'h3C);
      step(2);
      waitTxIdle(4 * 176);
      step(4);
      drain("loop3");

      for (int r = 0; r < 4; r++) begin
         int k;
         k = $urandom_range(1, 4);
         for (int j = 0; j < k; j++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            push(d);
            rxQ.push_back(d);
         end
         step(2);
         waitTxIdle(5 * 176);
         step(4);
         drain($sformatf("loopRnd%0d", r));
      end

      // ---------- TX FIFO full: sixth push is ignored ----------
      fullBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int j = 0; j < 5; j++) push(fullBytes[j]);
      checkOutput("txFullSendable", sendable, 0);
      push(8'hEE);
      got = 0;
      for (int c = 0; c < 7 * 176; c++) begin
         if (receivable === 1'b1) begin
            if (got < 5) checkOutput($sformatf("full_byte%0d", got), recv_data, fullBytes[got]);
            got++;
            recv_flag = 1'b1;
            step(1);
            recv_flag = 1'b0;
         end else begin
            step(1);
         end
      end
      checkOutput("fullRecvCount", got, 5);
      checkOutput("fullNoOverrun", err_overrun, 0);
      useLoop = 1'b0;

      // ---------- reset mid-frame, then a 1-cycle Rx glitch ----------
      push(8'h77);
      step(50);
      checkOutput("midFrameBusy", tx_busy, 1);
      #2;
      RST_N = 1'b0;
      #1;
      checkOutput("rstMid_Tx", Tx, 1);
      checkOutput("rstMid_busy", tx_busy, 0);
      checkOutput("rstMid_sendable", sendable, 1);
      checkOutput("rstMid_receivable", receivable, 0);
      step(2);
      RST_N = 1'b1;
      step(2);
      rxDrive = 1'b0;
      step(1);
      rxDrive = 1'b1;
      step(40);
      checkOutput("glitch_rcv", receivable, 0);
      checkOutput("glitch_errs", {err_parity, err_frame, err_overrun}, 0);
      checkOutput("postRst_busy", tx_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
